md_ctrl: RTL and testbench
==========================

Name: md_ctrl

Overview:
- Multi-cycle MIPS control unit: Moore FSM that sequences the multi-cycle datapath (IR/MDR/ALU_Out registers, shared memory port, PC register) one instruction at a time.
- Consumes the latched instruction, ALU `zero`/`overflow` and the bus `MIO_ready`.
- Produces every datapath select/enable plus memory read/write strobes.
- Sits between the datapath and the MIO bus inside the CPU top.

Parameters:
- OVF_TRAP, 1, when 1 add/sub/addi with overflow suppresses register writeback and pulses `exc_ovf`.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Inst  in  32  instruction register contents
- zero  in  1  ALU zero flag (combinational, current cycle)
- overflow  in  1  ALU signed overflow (combinational, current cycle)
- MIO_ready  in  1  memory/IO access completes this cycle
- PCWrite, PCWriteCond, Branch, IorD, IRWrite, RegWrite  out  1 each  datapath enables/selects
- PCSource  out  2  0=ALU res, 1=ALU_Out, 2=jump target, 3=rs
- ALUSrcA  out  2  0=PC, 1=rs, 2=shamt
- ALUSrcB  out  3  0=rt, 1=4, 2=sext imm, 3=sext imm<<2, 4=zext imm
- RegDst  out  2  0=rt, 1=rd, 2=$31
- MemtoReg  out  2  0=ALU_Out, 1=MDR, 2=lui imm, 3=PC
- ALU_operation  out  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SRL, 110 SUB, 111 SLT
- MemRead, MemWrite  out  1 each  bus strobes
- exc_ovf, ill_inst  out  1 each  one-cycle event pulses
- state  out  5  current state code (debug)

Behaviour:
- Reset low: state=IF immediately; all outputs forced 0 while reset is low. First fetch occurs on the first edge after release.
- Outputs are a pure decode of the state, plus opcode/funct in ID/EXE states. No output depends on MIO_ready except stall gating.
- IF:
  - IorD=0, MemRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=1, ADD, PCSource=0, PCWrite=1.
  - If MIO_ready=0: stay in IF with IRWrite=PCWrite=0. Otherwise go to ID.
- ID: ALUSrcA=0, ALUSrcB=3, ADD (branch target into ALU_Out). Dispatch:
  - lw/sw -> MA
  - R-type -> RX; funct jr -> JR
  - beq/bne -> BR
  - j -> J; jal -> JAL
  - addi/slti/andi/ori/xori -> IX
  - lui -> LUI
  - anything else -> IF, with ill_inst=1 for that ID cycle
- MA: ALUSrcA=1, ALUSrcB=2, ADD. Go to MR (lw) or MW (sw).
- MR: IorD=1, MemRead=1. Hold until MIO_ready=1, then go to LWB.
- LWB: RegDst=0, MemtoReg=1, RegWrite=1, then IF.
- MW: IorD=1, MemWrite=1. Hold until MIO_ready=1, then IF.
- RX: ALUSrcB=0. ALUSrcA=2 for srl, otherwise 1. ALU op from funct:
  - add 0x20, sub 0x22, and 0x24, or 0x25, xor 0x26, nor 0x27, slt 0x2A, srl 0x02
  - Go to RWB. If OVF_TRAP=1 and overflow=1 on add/sub: go to IF instead, with exc_ovf=1.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1, then IF.
- IX: ALUSrcA=1. ALUSrcB=2 for addi/slti, 4 for andi/ori/xori. Op ADD/SLT/AND/OR/XOR respectively. Overflow rule as RX for addi. Go to IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1, then IF.
- BR: ALUSrcA=1, ALUSrcB=0, SUB, PCWriteCond=1, Branch=1 for beq / 0 for bne, PCSource=1, then IF.
- J: PCSource=2, PCWrite=1, then IF.
- JAL: PCSource=2, PCWrite=1, RegDst=2, MemtoReg=3, RegWrite=1. $31 receives the pre-jump PC (already PC+4), then IF.
- JR: ALUSrcA=1, PCSource=3, PCWrite=1, then IF.
- LUI: RegDst=0, MemtoReg=2, RegWrite=1, then IF.
- Cycle counts with MIO_ready always 1:
  - lw 5
  - sw / R / I-type 4
  - beq/bne/j/jal/jr/lui 3
- Unused state codes decode to IF with all outputs 0.
- Reset asserted mid-instruction aborts it: no partial RegWrite or MemWrite after the reset falling edge.

Decomposition:
- Package md_ctrl_pkg holds:
  - state encodings
  - opcode/funct constants
  - ALU_operation codes
  - PCSource/ALUSrcA/ALUSrcB/RegDst/MemtoReg select constants
- Sub-module md_ctrl_decode: combinational opcode/funct to instruction class plus ALU op and ALUSrcB select. The FSM stays in md_ctrl.

Test Plan:
- reset=0 for 3 cycles, then release with MIO_ready=1 -> state=IF, all outputs 0 during reset; IRWrite=PCWrite=1 on the first post-reset cycle.
- Inst=0x8C880004 (lw), MIO_ready=0 for 2 cycles in MR -> states IF,ID,MA,MR,MR,MR,LWB. IorD=1/MemRead=1 held; RegWrite only in LWB.
- Inst=0x01095020 (add), overflow=1 in RX with OVF_TRAP=1 -> exc_ovf=1 for one cycle, next state IF, RegWrite never asserted.
- Inst=0x11090003 (beq) with zero=1, then bne 0x15090003 with zero=1 -> both give PCWriteCond=1, PCSource=1 in BR; Branch=1 vs 0.
- Inst=0x0C000010 (jal) -> JAL cycle shows PCWrite=1, PCSource=2, RegDst=2, MemtoReg=3, RegWrite=1; total 3 cycles.
- Inst=0xFC000000 (illegal opcode 0x3F) -> ill_inst=1 in ID, returns to IF, no RegWrite/MemWrite.

Source files
------------

// File: rtl/md_ctrl_pkg.sv
// rtl/md_ctrl_pkg.sv - state codes, opcode/funct constants and select encodings for md_ctrl
package md_ctrl_pkg;

  typedef enum logic [4:0] {
    S_IF  = 5'd0,
    S_ID  = 5'd1,
    S_MA  = 5'd2,
    S_MR  = 5'd3,
    S_LWB = 5'd4,
    S_MW  = 5'd5,
    S_RX  = 5'd6,
    S_RWB = 5'd7,
    S_IX  = 5'd8,
    S_IWB = 5'd9,
    S_BR  = 5'd10,
    S_J   = 5'd11,
    S_JAL = 5'd12,
    S_JR  = 5'd13,
    S_LUI = 5'd14
  } state_e;

  // Instruction classes produced by the decoder; each maps to one ID dispatch target
  typedef enum logic [3:0] {
    C_ILL, C_MEM, C_R, C_JR, C_BR, C_J, C_JAL, C_IMM, C_LUI
  } iclass_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_RS     = 2'd3;

  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_RS    = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  localparam logic [2:0] SRCB_RT    = 3'd0;
  localparam logic [2:0] SRCB_FOUR  = 3'd1;
  localparam logic [2:0] SRCB_SEXT  = 3'd2;
  localparam logic [2:0] SRCB_SEXT2 = 3'd3;
  localparam logic [2:0] SRCB_ZEXT  = 3'd4;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_LUI    = 2'd2;
  localparam logic [1:0] M2R_PC     = 2'd3;

  // Every control output of the unit, kept together so reset gating is one assignment
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch;
    logic       iord;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] pc_source;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       exc_ovf;
    logic       ill_inst;
  } ctrl_t;

endpackage

// File: rtl/md_ctrl_decode.sv
// rtl/md_ctrl_decode.sv - opcode/funct to instruction class, ALU op and ALUSrcB select
module md_ctrl_decode
  import md_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_e    iclass_o,
  output logic [2:0] alu_op_o,
  output logic [2:0] alu_src_b_o,
  output logic       ovf_chk_o,
  output logic       is_srl_o
);

  // Classify the instruction; unknown R-type functs are treated as illegal like unknown opcodes
  always_comb begin
    iclass_o    = C_ILL;
    alu_op_o    = ALU_ADD;
    alu_src_b_o = SRCB_RT;
    ovf_chk_o   = 1'b0;
    is_srl_o    = 1'b0;
    case (opcode_i)
      OP_RTYPE: begin
        iclass_o = C_R;
        case (funct_i)
          FN_ADD: begin alu_op_o = ALU_ADD; ovf_chk_o = 1'b1; end
          FN_SUB: begin alu_op_o = ALU_SUB; ovf_chk_o = 1'b1; end
          FN_AND: alu_op_o = ALU_AND;
          FN_OR:  alu_op_o = ALU_OR;
          FN_XOR: alu_op_o = ALU_XOR;
          FN_NOR: alu_op_o = ALU_NOR;
          FN_SLT: alu_op_o = ALU_SLT;
          FN_SRL: begin alu_op_o = ALU_SRL; is_srl_o = 1'b1; end
          FN_JR:  iclass_o = C_JR;
          default: iclass_o = C_ILL;
        endcase
      end
      OP_LW, OP_SW:   iclass_o = C_MEM;
      OP_BEQ, OP_BNE: begin iclass_o = C_BR; alu_op_o = ALU_SUB; end
      OP_J:           iclass_o = C_J;
      OP_JAL:         iclass_o = C_JAL;
      OP_LUI:         iclass_o = C_LUI;
      OP_ADDI: begin iclass_o = C_IMM; alu_op_o = ALU_ADD; alu_src_b_o = SRCB_SEXT; ovf_chk_o = 1'b1; end
      OP_SLTI: begin iclass_o = C_IMM; alu_op_o = ALU_SLT; alu_src_b_o = SRCB_SEXT; end
      OP_ANDI: begin iclass_o = C_IMM; alu_op_o = ALU_AND; alu_src_b_o = SRCB_ZEXT; end
      OP_ORI:  begin iclass_o = C_IMM; alu_op_o = ALU_OR;  alu_src_b_o = SRCB_ZEXT; end
      OP_XORI: begin iclass_o = C_IMM; alu_op_o = ALU_XOR; alu_src_b_o = SRCB_ZEXT; end
      default: iclass_o = C_ILL;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multi-cycle MIPS control FSM driving datapath selects and bus strobes
module md_ctrl
  import md_ctrl_pkg::*;
#(
  parameter bit OVF_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcA,
  output logic [2:0]  ALUSrcB,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic [2:0]  ALU_operation,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        exc_ovf,
  output logic        ill_inst,
  output logic [4:0]  state
);

  state_e     state_q, state_d;
  ctrl_t      c;
  iclass_e    iclass;
  logic [2:0] dec_alu_op;
  logic [2:0] dec_src_b;
  logic       dec_ovf_chk;
  logic       dec_is_srl;
  logic [5:0] opcode;
  logic [5:0] funct;

  // zero is consumed by the datapath's branch gating; register fields only matter there too
  logic unused_bits;
  assign unused_bits = ^{zero, Inst[25:6]};

  assign opcode = Inst[31:26];
  assign funct  = Inst[5:0];

  md_ctrl_decode u_decode (
    .opcode_i    (opcode),
    .funct_i     (funct),
    .iclass_o    (iclass),
    .alu_op_o    (dec_alu_op),
    .alu_src_b_o (dec_src_b),
    .ovf_chk_o   (dec_ovf_chk),
    .is_srl_o    (dec_is_srl)
  );

  // State register; reset drops straight back to fetch, aborting any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Next-state and Moore output decode; outputs are zeroed while reset is held low
  always_comb begin
    c       = '0;
    state_d = S_IF;
    case (state_q)
      S_IF: begin
        c.mem_read  = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCS_ALU;
        c.ir_write  = MIO_ready;
        c.pc_write  = MIO_ready;
        state_d     = MIO_ready ? S_ID : S_IF;
      end
      S_ID: begin
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_SEXT2;
        c.alu_op    = ALU_ADD;
        case (iclass)
          C_MEM:   state_d = S_MA;
          C_R:     state_d = S_RX;
          C_JR:    state_d = S_JR;
          C_BR:    state_d = S_BR;
          C_J:     state_d = S_J;
          C_JAL:   state_d = S_JAL;
          C_IMM:   state_d = S_IX;
          C_LUI:   state_d = S_LUI;
          default: begin c.ill_inst = 1'b1; state_d = S_IF; end
        endcase
      end
      S_MA: begin
        c.alu_src_a = SRCA_RS;
        c.alu_src_b = SRCB_SEXT;
        c.alu_op    = ALU_ADD;
        state_d     = (opcode == OP_LW) ? S_MR : S_MW;
      end
      S_MR: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
        state_d    = MIO_ready ? S_LWB : S_MR;
      end
      S_LWB: begin
        c.reg_dst    = DST_RT;
        c.mem_to_reg = M2R_MDR;
        c.reg_write  = 1'b1;
      end
      S_MW: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        state_d     = MIO_ready ? S_IF : S_MW;
      end
      S_RX, S_IX: begin
        c.alu_src_a = (state_q == S_RX && dec_is_srl) ? SRCA_SHAMT : SRCA_RS;
        c.alu_src_b = (state_q == S_RX) ? SRCB_RT : dec_src_b;
        c.alu_op    = dec_alu_op;
        if (OVF_TRAP && dec_ovf_chk && overflow) begin
          c.exc_ovf = 1'b1;
          state_d   = S_IF;
        end else begin
          state_d   = (state_q == S_RX) ? S_RWB : S_IWB;
        end
      end
      S_RWB: begin
        c.reg_dst    = DST_RD;
        c.mem_to_reg = M2R_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_IWB: begin
        c.reg_dst    = DST_RT;
        c.mem_to_reg = M2R_ALUOUT;
        c.reg_write  = 1'b1;
      end
      S_BR: begin
        c.alu_src_a     = SRCA_RS;
        c.alu_src_b     = SRCB_RT;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.branch        = (opcode == OP_BEQ);
        c.pc_source     = PCS_ALUOUT;
      end
      S_J: begin
        c.pc_source = PCS_JUMP;
        c.pc_write  = 1'b1;
      end
      S_JAL: begin
        c.pc_source  = PCS_JUMP;
        c.pc_write   = 1'b1;
        c.reg_dst    = DST_RA;
        c.mem_to_reg = M2R_PC;
        c.reg_write  = 1'b1;
      end
      S_JR: begin
        c.alu_src_a = SRCA_RS;
        c.pc_source = PCS_RS;
        c.pc_write  = 1'b1;
      end
      S_LUI: begin
        c.reg_dst    = DST_RT;
        c.mem_to_reg = M2R_LUI;
        c.reg_write  = 1'b1;
      end
      default: begin
        c       = '0;
        state_d = S_IF;
      end
    endcase
    if (!reset) c = '0;
  end

  assign PCWrite       = c.pc_write;
  assign PCWriteCond   = c.pc_write_cond;
  assign Branch        = c.branch;
  assign IorD          = c.iord;
  assign IRWrite       = c.ir_write;
  assign RegWrite      = c.reg_write;
  assign PCSource      = c.pc_source;
  assign ALUSrcA       = c.alu_src_a;
  assign ALUSrcB       = c.alu_src_b;
  assign RegDst        = c.reg_dst;
  assign MemtoReg      = c.mem_to_reg;
  assign ALU_operation = c.alu_op;
  assign MemRead       = c.mem_read;
  assign MemWrite      = c.mem_write;
  assign exc_ovf       = c.exc_ovf;
  assign ill_inst      = c.ill_inst;
  assign state         = state_q;

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - table-driven self-checking bench for md_ctrl
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Inst = 32'h0;
  logic        zero = 1'b0;
  logic        overflow = 1'b0;
  logic        MIO_ready = 1'b1;
  logic        PCWrite, PCWriteCond, Branch, IorD, IRWrite, RegWrite;
  logic [1:0]  PCSource, ALUSrcA, RegDst, MemtoReg;
  logic [2:0]  ALUSrcB, ALU_operation;
  logic        MemRead, MemWrite, exc_ovf, ill_inst;
  logic [4:0]  state;

  md_ctrl #(.OVF_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .Inst(Inst), .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .Branch(Branch), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALU_operation(ALU_operation), .MemRead(MemRead),
    .MemWrite(MemWrite), .exc_ovf(exc_ovf), .ill_inst(ill_inst), .state(state)
  );

  always #5 clk = ~clk;

  logic [23:0] act;
  assign act = {PCWrite, PCWriteCond, Branch, IorD, IRWrite, RegWrite, PCSource,
                ALUSrcA, ALUSrcB, RegDst, MemtoReg, ALU_operation,
                MemRead, MemWrite, exc_ovf, ill_inst};

  typedef struct {
    logic [31:0] inst;
    logic        mio;
    logic        ovf;
    logic        zr;
    logic [4:0]  st;
    logic [23:0] outs;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  function automatic logic [23:0] o(input int pcw, input int pcwc, input int br, input int iord,
                                    input int irw, input int rw, input int pcs, input int sa,
                                    input int sb, input int rd, input int mtr, input int op,
                                    input int mr, input int mw, input int exc, input int ill);
    return {1'(pcw), 1'(pcwc), 1'(br), 1'(iord), 1'(irw), 1'(rw), 2'(pcs), 2'(sa), 3'(sb),
            2'(rd), 2'(mtr), 3'(op), 1'(mr), 1'(mw), 1'(exc), 1'(ill)};
  endfunction

  task automatic add(input logic [31:0] i, input int m, input int v, input int z,
                     input int s, input logic [23:0] e);
    vec_t r;
    r.inst = i; r.mio = 1'(m); r.ovf = 1'(v); r.zr = 1'(z); r.st = 5'(s); r.outs = e;
    vecs.push_back(r);
  endtask

  localparam logic [31:0] I_LW   = 32'h8C880004;
  localparam logic [31:0] I_SW   = 32'hAD280008;
  localparam logic [31:0] I_ADD  = 32'h01095020;
  localparam logic [31:0] I_SRL  = 32'h00094082;
  localparam logic [31:0] I_BEQ  = 32'h11090003;
  localparam logic [31:0] I_BNE  = 32'h15090003;
  localparam logic [31:0] I_JAL  = 32'h0C000010;
  localparam logic [31:0] I_J    = 32'h08000010;
  localparam logic [31:0] I_JR   = 32'h01000008;
  localparam logic [31:0] I_ADDI = 32'h21090005;
  localparam logic [31:0] I_ORI  = 32'h35090005;
  localparam logic [31:0] I_LUI  = 32'h3C091234;
  localparam logic [31:0] I_ILL  = 32'hFC000000;

  logic [23:0] o_if, o_ifs, o_id, o_idill, o_ma, o_mr, o_lwb, o_mw, o_rxadd, o_rxovf, o_rxsrl;
  logic [23:0] o_rwb, o_ixaddi, o_ixori, o_iwb, o_beq, o_bne, o_jal, o_jr, o_j, o_lui;

  initial begin
    int cyc;
    int mr_cnt;
    //            pcw pcwc br iord irw rw pcs sa sb rd mtr op mr mw exc ill
    o_if     = o(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    o_ifs    = o(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    o_id     = o(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2, 0, 0, 0, 0);
    o_idill  = o(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2, 0, 0, 0, 1);
    o_ma     = o(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0, 0);
    o_mr     = o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    o_lwb    = o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    o_mw     = o(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    o_rxadd  = o(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0);
    o_rxovf  = o(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 1, 0);
    o_rxsrl  = o(0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 5, 0, 0, 0, 0);
    o_rwb    = o(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    o_ixaddi = o(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0, 0);
    o_ixori  = o(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 0, 0, 0);
    o_iwb    = o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    o_beq    = o(0, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 6, 0, 0, 0, 0);
    o_bne    = o(0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 6, 0, 0, 0, 0);
    o_jal    = o(1, 0, 0, 0, 0, 1, 2, 0, 0, 2, 3, 0, 0, 0, 0, 0);
    o_jr     = o(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    o_j      = o(1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    o_lui    = o(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0);

    //   inst    mio ovf zr state outs
    add(I_LW,   1, 0, 0, 0,  o_if);
    add(I_LW,   1, 0, 0, 1,  o_id);
    add(I_LW,   1, 0, 0, 2,  o_ma);
    add(I_LW,   0, 0, 0, 3,  o_mr);
    add(I_LW,   0, 0, 0, 3,  o_mr);
    add(I_LW,   1, 0, 0, 3,  o_mr);
    add(I_LW,   1, 0, 0, 4,  o_lwb);
    add(I_ADD,  1, 0, 0, 0,  o_if);
    add(I_ADD,  1, 0, 0, 1,  o_id);
    add(I_ADD,  1, 1, 0, 6,  o_rxovf);
    add(I_BEQ,  1, 0, 1, 0,  o_if);
    add(I_BEQ,  1, 0, 1, 1,  o_id);
    add(I_BEQ,  1, 0, 1, 10, o_beq);
    add(I_BNE,  1, 0, 1, 0,  o_if);
    add(I_BNE,  1, 0, 1, 1,  o_id);
    add(I_BNE,  1, 0, 1, 10, o_bne);
    add(I_JAL,  1, 0, 0, 0,  o_if);
    add(I_JAL,  1, 0, 0, 1,  o_id);
    add(I_JAL,  1, 0, 0, 12, o_jal);
    add(I_ILL,  1, 0, 0, 0,  o_if);
    add(I_ILL,  1, 0, 0, 1,  o_idill);
    add(I_SW,   1, 0, 0, 0,  o_if);
    add(I_SW,   1, 0, 0, 1,  o_id);
    add(I_SW,   1, 0, 0, 2,  o_ma);
    add(I_SW,   1, 0, 0, 5,  o_mw);
    add(I_ADD,  1, 0, 0, 0,  o_if);
    add(I_ADD,  1, 0, 0, 1,  o_id);
    add(I_ADD,  1, 0, 0, 6,  o_rxadd);
    add(I_ADD,  1, 0, 0, 7,  o_rwb);
    add(I_SRL,  1, 0, 0, 0,  o_if);
    add(I_SRL,  1, 0, 0, 1,  o_id);
    add(I_SRL,  1, 0, 0, 6,  o_rxsrl);
    add(I_SRL,  1, 0, 0, 7,  o_rwb);
    add(I_ADDI, 1, 0, 0, 0,  o_if);
    add(I_ADDI, 1, 0, 0, 1,  o_id);
    add(I_ADDI, 1, 0, 0, 8,  o_ixaddi);
    add(I_ADDI, 1, 0, 0, 9,  o_iwb);
    add(I_ORI,  1, 0, 0, 0,  o_if);
    add(I_ORI,  1, 0, 0, 1,  o_id);
    add(I_ORI,  1, 0, 0, 8,  o_ixori);
    add(I_ORI,  1, 0, 0, 9,  o_iwb);
    add(I_LUI,  1, 0, 0, 0,  o_if);
    add(I_LUI,  1, 0, 0, 1,  o_id);
    add(I_LUI,  1, 0, 0, 14, o_lui);
    add(I_JR,   1, 0, 0, 0,  o_if);
    add(I_JR,   1, 0, 0, 1,  o_id);
    add(I_JR,   1, 0, 0, 13, o_jr);
    add(I_J,    1, 0, 0, 0,  o_if);
    add(I_J,    1, 0, 0, 1,  o_id);
    add(I_J,    1, 0, 0, 11, o_j);
    add(I_SW,   0, 0, 0, 0,  o_ifs);
    add(I_SW,   1, 0, 0, 0,  o_if);
    add(I_SW,   1, 0, 0, 1,  o_id);
    add(I_SW,   1, 0, 0, 2,  o_ma);

    // Reset held for three cycles with a fetch-ready bus: IF code, every output zero
    Inst = I_LW;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check($sformatf("reset_state[%0d]", i), 32'(state), 32'd0);
      check($sformatf("reset_outs[%0d]", i), 32'(act), 32'd0);
    end

    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      Inst = vecs[i].inst; MIO_ready = vecs[i].mio;
      overflow = vecs[i].ovf; zero = vecs[i].zr;
      #1;
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("vec%0d_outs", i), 32'(act), 32'(vecs[i].outs));
      @(negedge clk);
    end
    overflow = 1'b0; zero = 1'b0;

    // Store in progress while the bus stalls; reset mid-cycle must kill MemWrite at once
    MIO_ready = 1'b0;
    #1;
    check("mw_stall_state", 32'(state), 32'd5);
    check("mw_stall_memwrite", 32'(MemWrite), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_state", 32'(state), 32'd0);
    check("abort_outs", 32'(act), 32'd0);
    @(negedge clk); #1;
    check("abort_hold_state", 32'(state), 32'd0);
    check("abort_hold_outs", 32'(act), 32'd0);
    MIO_ready = 1'b1;
    reset = 1'b1;
    #1;
    check("release_outs", 32'(act), 32'(o_if));

    // lw with four bus-stall cycles in MR, bounded wait for writeback
    Inst = I_LW;
    cyc = 0;
    mr_cnt = 0;
    while (state != 5'd4 && cyc < 30) begin
      if (state == 5'd3) begin
        MIO_ready = (mr_cnt >= 4);
        mr_cnt++;
      end else begin
        MIO_ready = 1'b1;
      end
      @(negedge clk); #1;
      cyc++;
    end
    check("lw_wait_reached_lwb", 32'(state), 32'd4);
    check("lw_wait_cycles", 32'(cyc), 32'd8);
    check("lw_wait_mr_cycles", 32'(mr_cnt), 32'd5);
    check("lw_wait_regwrite", 32'(RegWrite), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
